spatz_vfu_req_queue: RTL and testbench

Request queue between the Spatz controller and the vector functional unit (VFU). Buffers up to DEPTH VFU-bound `spatz_req_t` requests and presents them in order to the VFU's valid/ready port. Holds issue of the head request while it would read a vector register still being written by the VFU's in-flight operation (RAW hazard). Requests with `vl == 0` are retired without issue.

---
 rtl/spatz_pkg.sv | 36 +++
 rtl/spatz_vfu_hazard_check.sv | 40 ++++
 rtl/spatz_vfu_req_queue.sv | 207 ++++++++++++++++++++
 tb/tb_spatz_vfu_req_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/spatz_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spatz_pkg
//  Description : Shared Spatz types: execution-unit enum, vector register
//                index type and the controller request structure.
//  Revision    : 1.0 - initial release
// ============================================================================
package spatz_pkg;

    localparam int unsigned NRVREGS = 32;

    typedef enum logic [1:0] {
        VFU  = 2'd0,
        LSU  = 2'd1,
        SLDU = 2'd2,
        NONE = 2'd3
    } ex_unit_e;

    typedef logic [$clog2(NRVREGS)-1:0] vreg_t;
    typedef logic [15:0]                vlen_t;

    typedef struct packed {
        ex_unit_e    ex_unit;
        logic [7:0]  op;
        vlen_t       vl;
        vreg_t       vd;
        vreg_t       vs1;
        vreg_t       vs2;
        logic        use_vd;
        logic        use_vs1;
        logic        use_vs2;
        logic        vd_is_src;
    } spatz_req_t;

endpackage
`default_nettype wire

// File: rtl/spatz_vfu_hazard_check.sv
`default_nettype none
// ============================================================================
//  Module      : spatz_vfu_hazard_check
//  Description : Combinational RAW check of a request's source registers
//                (vs1, vs2, and vd when it is also read) against the vector
//                register currently being written by the in-flight VFU op.
//  Ports       : inflight_i/inflight_vd_i - in-flight tracker state
//                vs1_i/vs2_i/vd_i, use_*_i, vd_is_src_i - request operands
//                hazard_o - request reads the in-flight destination
//  Revision    : 1.0 - initial release
// ============================================================================
module spatz_vfu_hazard_check
    import spatz_pkg::*;
#(
    parameter int unsigned NrVregs = 32,
    localparam int unsigned VREG_W = $clog2(NrVregs)
) (
    input  logic              inflight_i,
    input  logic [VREG_W-1:0] inflight_vd_i,
    input  vreg_t             vs1_i,
    input  vreg_t             vs2_i,
    input  vreg_t             vd_i,
    input  logic              use_vs1_i,
    input  logic              use_vs2_i,
    input  logic              vd_is_src_i,
    output logic              hazard_o
);

    logic w_vs1_hit;
    logic w_vs2_hit;
    logic w_vd_hit;

    assign w_vs1_hit = use_vs1_i   && (vs1_i[VREG_W-1:0] == inflight_vd_i);
    assign w_vs2_hit = use_vs2_i   && (vs2_i[VREG_W-1:0] == inflight_vd_i);
    assign w_vd_hit  = vd_is_src_i && (vd_i[VREG_W-1:0]  == inflight_vd_i);

    assign hazard_o = inflight_i && (w_vs1_hit || w_vs2_hit || w_vd_hit);

endmodule
`default_nettype wire

// File: rtl/spatz_vfu_req_queue.sv
`default_nettype none
// ============================================================================
//  Module      : spatz_vfu_req_queue
//  Description : In-order request queue from the Spatz controller to the VFU.
//                Filters VFU-bound requests, retires vl==0 requests without
//                issue, and stalls the head on a RAW hazard against the VFU's
//                in-flight destination register.
//  Config      : SPATZ_VFU_REQ_BYPASS_EN - empty-queue push is presented to
//                the VFU in the same cycle (combinational req -> vfu path).
//  Ports       : clk_i, rst_i (sync, active-high)
//                req_i/req_valid_i/req_ready_o       - controller side
//                vfu_req_o/vfu_req_valid_o/vfu_req_ready_i - VFU side
//                vfu_done_i - VFU finished writing its destination
//                usage_o    - occupancy, hazard_o - head stalled on RAW
//  Revision    : 1.0 - initial release
// ============================================================================
module spatz_vfu_req_queue
    import spatz_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NrVregs = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  spatz_req_t               req_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    output spatz_req_t               vfu_req_o,
    output logic                     vfu_req_valid_o,
    input  logic                     vfu_req_ready_i,
    input  logic                     vfu_done_i,
    output logic [$clog2(DEPTH):0]   usage_o,
    output logic                     hazard_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned VREG_W = $clog2(NrVregs);

    // ex_unit is implied by residency in this queue, so it is not stored.
    typedef struct packed {
        logic [7:0] op;
        vlen_t      vl;
        vreg_t      vd;
        vreg_t      vs1;
        vreg_t      vs2;
        logic       use_vd;
        logic       use_vs1;
        logic       use_vs2;
        logic       vd_is_src;
    } entry_t;

    function automatic entry_t to_entry(input spatz_req_t r);
        entry_t e;
        e.op        = r.op;
        e.vl        = r.vl;
        e.vd        = r.vd;
        e.vs1       = r.vs1;
        e.vs2       = r.vs2;
        e.use_vd    = r.use_vd;
        e.use_vs1   = r.use_vs1;
        e.use_vs2   = r.use_vs2;
        e.vd_is_src = r.vd_is_src;
        return e;
    endfunction

    function automatic spatz_req_t from_entry(input entry_t e);
        spatz_req_t r;
        r.ex_unit   = VFU;
        r.op        = e.op;
        r.vl        = e.vl;
        r.vd        = e.vd;
        r.vs1       = e.vs1;
        r.vs2       = e.vs2;
        r.use_vd    = e.use_vd;
        r.use_vs1   = e.use_vs1;
        r.use_vs2   = e.use_vs2;
        r.vd_is_src = e.vd_is_src;
        return r;
    endfunction

    entry_t              mem_q [DEPTH];
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [CNT_W-1:0]    usage_q, usage_d;
    logic                inflight_q, inflight_d;
    logic [VREG_W-1:0]   inflight_vd_q, inflight_vd_d;

    logic       w_empty;
    logic       w_full;
    logic       w_push;
    logic       w_write;
    logic       w_pop;
    logic       w_issue;
    logic       w_bypass;
    logic       w_head_zero;
    logic       w_head_hazard;
    logic       w_head_valid;
    spatz_req_t w_head_req;

    assign w_empty     = (usage_q == '0);
    assign w_full      = (usage_q == CNT_W'(DEPTH));
    assign req_ready_o = !w_full;
    assign w_push      = req_valid_i && !w_full && (req_i.ex_unit == VFU);

    assign w_head_req  = from_entry(mem_q[rptr_q]);
    assign w_head_zero = (w_head_req.vl == '0);

    spatz_vfu_hazard_check #(
        .NrVregs (NrVregs)
    ) i_head_hazard (
        .inflight_i    (inflight_q),
        .inflight_vd_i (inflight_vd_q),
        .vs1_i         (w_head_req.vs1),
        .vs2_i         (w_head_req.vs2),
        .vd_i          (w_head_req.vd),
        .use_vs1_i     (w_head_req.use_vs1),
        .use_vs2_i     (w_head_req.use_vs2),
        .vd_is_src_i   (w_head_req.vd_is_src),
        .hazard_o      (w_head_hazard)
    );

    assign w_head_valid = !w_empty && !w_head_zero && !w_head_hazard;
    assign hazard_o     = !w_empty && !w_head_zero && w_head_hazard;

`ifdef SPATZ_VFU_REQ_BYPASS_EN
    logic w_byp_hazard;

    spatz_vfu_hazard_check #(
        .NrVregs (NrVregs)
    ) i_byp_hazard (
        .inflight_i    (inflight_q),
        .inflight_vd_i (inflight_vd_q),
        .vs1_i         (req_i.vs1),
        .vs2_i         (req_i.vs2),
        .vd_i          (req_i.vd),
        .use_vs1_i     (req_i.use_vs1),
        .use_vs2_i     (req_i.use_vs2),
        .vd_is_src_i   (req_i.vd_is_src),
        .hazard_o      (w_byp_hazard)
    );

    assign w_bypass        = w_empty && w_push && (req_i.vl != '0) && !w_byp_hazard;
    assign vfu_req_o       = w_bypass ? req_i : w_head_req;
`else
    assign w_bypass        = 1'b0;
    assign vfu_req_o       = w_head_req;
`endif

    assign vfu_req_valid_o = w_head_valid || w_bypass;
    assign w_issue         = vfu_req_valid_o && vfu_req_ready_i;
    // Zero-length heads drain unconditionally; a bypassed request never
    // occupies the head, so pops only ever come from storage.
    assign w_pop           = !w_empty && (w_head_zero || (w_head_valid && vfu_req_ready_i));
    // A bypassed request accepted by the VFU is consumed without storage.
    assign w_write         = w_push && !(w_bypass && vfu_req_ready_i);

    always_comb begin
        rptr_d        = rptr_q;
        wptr_d        = wptr_q;
        usage_d       = usage_q;
        inflight_d    = inflight_q;
        inflight_vd_d = inflight_vd_q;

        if (w_write) wptr_d = wptr_q + PTR_W'(1);
        if (w_pop)   rptr_d = rptr_q + PTR_W'(1);

        case ({w_write, w_pop})
            2'b10:   usage_d = usage_q + CNT_W'(1);
            2'b01:   usage_d = usage_q - CNT_W'(1);
            default: usage_d = usage_q;
        endcase

        // A new issue takes precedence over a completing older op.
        if (w_issue && vfu_req_o.use_vd) begin
            inflight_d    = 1'b1;
            inflight_vd_d = vfu_req_o.vd[VREG_W-1:0];
        end else if (vfu_done_i) begin
            inflight_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q        <= '0;
            wptr_q        <= '0;
            usage_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_vd_q <= '0;
        end else begin
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            usage_q       <= usage_d;
            inflight_q    <= inflight_d;
            inflight_vd_q <= inflight_vd_d;
        end
    end

    // Payload storage needs no reset: entries are only read while valid.
    always_ff @(posedge clk_i) begin
        if (w_write) mem_q[wptr_q] <= to_entry(req_i);
    end

    assign usage_o = usage_q;

endmodule
`default_nettype wire

// File: tb/tb_spatz_vfu_req_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spatz_vfu_req_queue
//  Description : Directed self-checking bench for spatz_vfu_req_queue
//                (default build: no bypass).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spatz_vfu_req_queue;
    import spatz_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    spatz_req_t  req;
    logic        req_valid;
    logic        req_ready;
    spatz_req_t  vfu_req;
    logic        vfu_valid;
    logic        vfu_ready;
    logic        vfu_done;
    logic [2:0]  usage;
    logic        hazard;

    int checks = 0;
    int fails  = 0;

    spatz_vfu_req_queue #(
        .DEPTH   (4),
        .NrVregs (32)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_i           (req),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .vfu_req_o       (vfu_req),
        .vfu_req_valid_o (vfu_valid),
        .vfu_req_ready_i (vfu_ready),
        .vfu_done_i      (vfu_done),
        .usage_o         (usage),
        .hazard_o        (hazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // fl = {use_vd, use_vs1, use_vs2, vd_is_src}
    function automatic spatz_req_t mk(input ex_unit_e ex, input logic [15:0] vl,
                                      input logic [4:0] vd, input logic [4:0] vs1,
                                      input logic [4:0] vs2, input logic [3:0] fl);
        spatz_req_t r;
        r.ex_unit   = ex;
        r.op        = 8'h11;
        r.vl        = vl;
        r.vd        = vd;
        r.vs1       = vs1;
        r.vs2       = vs2;
        r.use_vd    = fl[3];
        r.use_vs1   = fl[2];
        r.use_vs2   = fl[1];
        r.vd_is_src = fl[0];
        return r;
    endfunction

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1; req_valid = 1'b0; vfu_ready = 1'b0; vfu_done = 1'b0;
        req = mk(VFU, 16'd0, 5'd0, 5'd0, 5'd0, 4'b0000);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_ready",  32'(req_ready), 32'd1);
        chk("rst_valid",  32'(vfu_valid), 32'd0);
        chk("rst_usage",  32'(usage),     32'd0);
        chk("rst_hazard", 32'(hazard),    32'd0);

        // ---------------- filter ----------------
        req = mk(LSU, 16'd8, 5'd1, 5'd0, 5'd0, 4'b1000); req_valid = 1'b1;
        #1;
        chk("lsu_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        #1;
        chk("lsu_usage", 32'(usage),     32'd0);
        chk("lsu_valid", 32'(vfu_valid), 32'd0);

        // ---------------- fill ----------------
        req = mk(VFU, 16'd8, 5'd10, 5'd0, 5'd0, 4'b0000); req_valid = 1'b1;
        tick();
        chk("fill_lat1_valid", 32'(vfu_valid), 32'd1);
        chk("fill_usage1",     32'(usage),     32'd1);
        req = mk(VFU, 16'd8, 5'd11, 5'd0, 5'd0, 4'b0000);
        tick();
        req = mk(VFU, 16'd8, 5'd12, 5'd0, 5'd0, 4'b0000);
        tick();
        req = mk(VFU, 16'd8, 5'd13, 5'd0, 5'd0, 4'b0000);
        tick();
        req_valid = 1'b0;
        #1;
        chk("fill_usage4", 32'(usage),     32'd4);
        chk("fill_ready0", 32'(req_ready), 32'd0);
        chk("fill_head",   32'(vfu_req.vd), 32'd10);
        vfu_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_valid", 32'(vfu_valid),  32'd1);
            chk("drain_order", 32'(vfu_req.vd), 32'(10 + i));
            tick();
        end
        chk("drain_valid_end", 32'(vfu_valid), 32'd0);
        chk("drain_usage_end", 32'(usage),     32'd0);

        // ---------------- RAW stall ----------------
        req = mk(VFU, 16'd8, 5'd3, 5'd0, 5'd0, 4'b1000); req_valid = 1'b1;
        tick();
        req = mk(VFU, 16'd8, 5'd0, 5'd0, 5'd3, 4'b0010);
        tick();
        req_valid = 1'b0;
        #1;
        chk("raw_valid0",  32'(vfu_valid), 32'd0);
        chk("raw_hazard1", 32'(hazard),    32'd1);
        chk("raw_usage1",  32'(usage),     32'd1);
        tick();
        chk("raw_hold_hazard", 32'(hazard),    32'd1);
        chk("raw_hold_valid",  32'(vfu_valid), 32'd0);
        vfu_done = 1'b1;
        #1;
        chk("raw_done_cycle_valid", 32'(vfu_valid), 32'd0);
        tick();
        vfu_done = 1'b0;
        #1;
        chk("raw_release_valid",  32'(vfu_valid),   32'd1);
        chk("raw_release_hazard", 32'(hazard),      32'd0);
        chk("raw_release_vs2",    32'(vfu_req.vs2), 32'd3);
        tick();
        chk("raw_usage_end", 32'(usage), 32'd0);

        // ---------------- done + issue same cycle ----------------
        vfu_ready = 1'b0; req_valid = 1'b1;
        req = mk(VFU, 16'd8, 5'd3, 5'd0, 5'd0, 4'b1000); tick();
        req = mk(VFU, 16'd8, 5'd5, 5'd0, 5'd0, 4'b1000); tick();
        req = mk(VFU, 16'd8, 5'd0, 5'd0, 5'd3, 4'b0010); tick();
        req = mk(VFU, 16'd8, 5'd0, 5'd5, 5'd0, 4'b0100); tick();
        req_valid = 1'b0; vfu_ready = 1'b1;
        tick();
        vfu_done = 1'b1;
        #1;
        chk("di_q_valid", 32'(vfu_valid),  32'd1);
        chk("di_q_vd",    32'(vfu_req.vd), 32'd5);
        tick();
        vfu_done = 1'b0;
        #1;
        chk("di_v3_reader_valid",  32'(vfu_valid),   32'd1);
        chk("di_v3_reader_hazard", 32'(hazard),      32'd0);
        chk("di_v3_reader_vs2",    32'(vfu_req.vs2), 32'd3);
        tick();
        chk("di_v5_reader_valid",  32'(vfu_valid),   32'd0);
        chk("di_v5_reader_hazard", 32'(hazard),      32'd1);
        chk("di_v5_reader_vs1",    32'(vfu_req.vs1), 32'd5);
        vfu_done = 1'b1;
        tick();
        vfu_done = 1'b0;
        #1;
        chk("di_v5_release", 32'(vfu_valid), 32'd1);
        tick();
        chk("di_usage_end", 32'(usage), 32'd0);

        // ---------------- zero-length ----------------
        vfu_ready = 1'b0;
        req = mk(VFU, 16'd0, 5'd7, 5'd0, 5'd0, 4'b1000); req_valid = 1'b1;
        tick();
        req = mk(VFU, 16'd8, 5'd0, 5'd7, 5'd0, 4'b0100);
        #1;
        chk("zl_head_valid",  32'(vfu_valid), 32'd0);
        chk("zl_head_usage",  32'(usage),     32'd1);
        chk("zl_head_hazard", 32'(hazard),    32'd0);
        tick();
        req_valid = 1'b0;
        #1;
        chk("zl_next_usage", 32'(usage),      32'd1);
        chk("zl_next_valid", 32'(vfu_valid),  32'd1);
        chk("zl_next_vl",    32'(vfu_req.vl), 32'd8);
        vfu_ready = 1'b1;
        tick();
        chk("zl_usage_end", 32'(usage), 32'd0);

        // ---------------- reset mid-operation ----------------
        req = mk(VFU, 16'd8, 5'd9, 5'd0, 5'd0, 4'b1000); req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        vfu_ready = 1'b0;
        req = mk(VFU, 16'd8, 5'd0, 5'd9, 5'd0, 4'b0100); req_valid = 1'b1;
        tick(); tick(); tick();
        req_valid = 1'b0;
        #1;
        chk("pre_rst_usage",  32'(usage),     32'd3);
        chk("pre_rst_hazard", 32'(hazard),    32'd1);
        chk("pre_rst_valid",  32'(vfu_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_usage",  32'(usage),     32'd0);
        chk("mid_rst_valid",  32'(vfu_valid), 32'd0);
        chk("mid_rst_hazard", 32'(hazard),    32'd0);
        chk("mid_rst_ready",  32'(req_ready), 32'd1);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        #1;
        chk("post_rst_valid",  32'(vfu_valid), 32'd1);
        chk("post_rst_hazard", 32'(hazard),    32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire
